// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC and PRId,
// the combined int_req to the M stage, and the EPC used by eret.
module cp0_intc #(
  parameter logic [31:0] PRID       = 32'h2018_0007,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] exc_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        hwirq;
  logic        excp;
  logic [31:0] victim_pc;

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  // Raw hw_int feeds the request so a device edge costs no extra cycle.
  assign hwirq   = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign excp    = (exc_code_in != 5'd0) & ~sr_exl;
  assign int_req = hwirq | excp;

  assign victim_pc = bd_in ? (pc_in - 32'd4) : pc_in;

  assign epc_out = epc;
  assign exc_pc  = EXC_VECTOR;

  always_comb begin
    rd_data = 32'b0;
    case (rd_addr)
      ADDR_SR:    rd_data = sr_word;
      ADDR_CAUSE: rd_data = cause_word;
      ADDR_EPC:   rd_data = epc;
      ADDR_PRID:  rd_data = PRID;
      default:    rd_data = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'b0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'b0;
      cause_exc <= 5'b0;
      epc       <= 32'b0;
    end else begin
      cause_ip <= hw_int;
      if (int_req) begin
        // Entry flushes the victim, so a same-cycle mtc0 or eret is dropped.
        sr_exl    <= 1'b1;
        cause_exc <= hwirq ? 5'd0 : exc_code_in;
        cause_bd  <= bd_in;
        epc       <= {victim_pc[31:2], 2'b00};
      end else begin
        if (wr_en && (wr_addr == ADDR_SR)) begin
          sr_im  <= wr_data[15:10];
          sr_exl <= wr_data[1];
          sr_ie  <= wr_data[0];
        end
        if (wr_en && (wr_addr == ADDR_EPC))
          epc <= {wr_data[31:2], 2'b00};
        // Placed after the SR write so eret's EXL clear takes precedence.
        if (eret)
          sr_exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: expectations are queued as each step is
// driven and popped when the corresponding output is sampled.
module tb_cp0_intc;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic [31:0] exc_pc;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int errors = 0;
  int checks = 0;

  cp0_intc dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_in(pc_in), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .eret(eret),
    .int_req(int_req), .epc_out(epc_out), .exc_pc(exc_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic exp_push(input string tag, input logic [31:0] v);
    sb_entry_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic sb_cmp(input logic [31:0] obs);
    sb_entry_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] v);
    exp_push(tag, v);
    rd_addr = a;
    #1;
    sb_cmp(rd_data);
  endtask

  task automatic req(input string tag, input logic v);
    exp_push(tag, {31'b0, v});
    #1;
    sb_cmp({31'b0, int_req});
  endtask

  task automatic epc_chk(input string tag, input logic [31:0] v);
    exp_push(tag, v);
    #1;
    sb_cmp(epc_out);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'b0;
    exc_code_in = 5'd0; bd_in = 1'b0; eret = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    reset = 1'b1; rd_addr = 5'd0; pc_in = 32'b0; hw_int = 6'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    hw_int = 6'b000001;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h2018_0007);
    rd("rst_other", 5'd3, 32'h0);
    req("rst_req", 1'b0);
    epc_chk("rst_epc_out", 32'h0);
    exp_push("exc_pc", 32'h0000_4180);
    sb_cmp(exc_pc);
    @(negedge clk);
    req("rst_req_held", 1'b0);
    rd("rst_cause_ip", 5'd13, 32'h0000_0400);

    // timer interrupt
    hw_int = 6'b0;
    mtc0(5'd12, 32'h0000_0401);
    @(negedge clk);
    idle();
    pc_in = 32'h0000_3010;
    hw_int = 6'b000001;
    req("tmr_req", 1'b1);
    @(negedge clk);
    req("tmr_req_after", 1'b0);
    rd("tmr_sr", 5'd12, 32'h0000_0403);
    rd("tmr_cause", 5'd13, 32'h0000_0400);
    rd("tmr_epc", 5'd14, 32'h0000_3010);

    // eret with hw_int held: re-trigger next cycle
    eret = 1'b1;
    req("eret_req", 1'b0);
    epc_chk("eret_epc_out", 32'h0000_3010);
    @(negedge clk);
    idle();
    pc_in = 32'h0000_3014;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    req("eret_retrig", 1'b1);
    @(negedge clk);
    rd("retrig_epc", 5'd14, 32'h0000_3014);

    // masked interrupt; mtc0 clears EXL too
    hw_int = 6'b0;
    mtc0(5'd12, 32'h0000_0801);
    @(negedge clk);
    idle();
    hw_int = 6'b000001;
    req("mask_req", 1'b0);
    rd("mask_ip_before", 5'd13, 32'h0);
    @(negedge clk);
    req("mask_req2", 1'b0);
    rd("mask_ip_after", 5'd13, 32'h0000_0400);
    rd("mask_epc", 5'd14, 32'h0000_3014);

    // Cause is read-only, EPC low bits forced
    mtc0(5'd13, 32'hFFFF_FFFF);
    @(negedge clk);
    mtc0(5'd14, 32'h0000_1237);
    rd("cause_ro", 5'd13, 32'h0000_0400);
    @(negedge clk);
    idle();
    rd("epc_wr", 5'd14, 32'h0000_1234);

    // exception in delay slot
    hw_int = 6'b0;
    mtc0(5'd12, 32'h0);
    @(negedge clk);
    idle();
    exc_code_in = 5'd12; bd_in = 1'b1; pc_in = 32'h0000_3020;
    req("dly_req", 1'b1);
    @(negedge clk);
    idle();
    rd("dly_cause", 5'd13, 32'h8000_0030);
    rd("dly_epc", 5'd14, 32'h0000_301C);
    rd("dly_sr", 5'd12, 32'h0000_0002);

    // interrupt + exception + mtc0 EPC in the same cycle
    mtc0(5'd12, 32'h0000_0401);
    @(negedge clk);
    mtc0(5'd14, 32'h1234_5678);
    hw_int = 6'b000001; exc_code_in = 5'd10; pc_in = 32'h0000_3040;
    req("cfl_req", 1'b1);
    @(negedge clk);
    idle();
    rd("cfl_cause", 5'd13, 32'h0000_0400);
    rd("cfl_epc", 5'd14, 32'h0000_3040);

    // mtc0 SR with eret: EXL cleared, other bits from wr_data
    hw_int = 6'b0;
    mtc0(5'd12, 32'h0000_0803);
    eret = 1'b1;
    req("wre_req", 1'b0);
    @(negedge clk);
    idle();
    rd("wre_sr", 5'd12, 32'h0000_0801);

    // entry with eret, pc wrap in delay slot
    exc_code_in = 5'd4; bd_in = 1'b1; pc_in = 32'h0; eret = 1'b1;
    req("wrap_req", 1'b1);
    @(negedge clk);
    idle();
    rd("wrap_sr", 5'd12, 32'h0000_0803);
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0010);

    // reset mid-handler
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hw_int = 6'b000001;
    rd("mid_sr", 5'd12, 32'h0);
    rd("mid_epc", 5'd14, 32'h0);
    rd("mid_cause", 5'd13, 32'h0);
    req("mid_req", 1'b0);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 interrupt/exception controller; the receiving end of the device IRQ lines (timer DEV0 IRQ on hw_int[0], second device on hw_int[1]).
- Holds SR, Cause, EPC and PRId.
- Combines masked hardware interrupts with the internal exception code from the pipeline and raises a single int_req to the CPU M stage.
- Records the victim PC on entry and supplies EPC for eret.

Parameters:
PRID, 32'h2018_0007, constant value returned on reads of register 15.
EXC_VECTOR, 32'h0000_4180, handler entry address driven on exc_pc.

Ports:
clk  input  1  clock
reset  input  1  reset
rd_addr  input  5  CP0 register number for mfc0
rd_data  output  32  combinational read data
wr_en  input  1  mtc0 write strobe
wr_addr  input  5  CP0 register number for mtc0
wr_data  input  32  mtc0 data
pc_in  input  32  PC of instruction in M stage (victim)
bd_in  input  1  victim is in a branch delay slot
exc_code_in  input  5  internal exception code, 0 = none
hw_int  input  6  device interrupt lines, bit0 = timer 0, bit1 = timer 1, others tied by top
eret  input  1  eret in M stage
int_req  output  1  take interrupt/exception this cycle
epc_out  output  32  current EPC, for eret redirect
exc_pc  output  32  constant EXC_VECTOR

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Reset values: SR = 0, Cause = 0, EPC = 0. Consequently int_req = 0 and epc_out = 0.
- SR (reg 12):
  - Implemented bits: IM = [15:10], EXL = [1], IE = [0].
  - All other bits read 0.
  - Writable by mtc0.
- Cause (reg 13):
  - Implemented bits: BD = [31], IP = [15:10], ExcCode = [6:2].
  - All other bits read 0.
  - Read-only; mtc0 to 13 is ignored.
  - IP <= hw_int every cycle, including while EXL = 1 (registered, 1-cycle latency).
  - IP is the only Cause field updated outside interrupt entry.
- EPC (reg 14): writable by mtc0, with wr_data[1:0] forced to 00.
- PRId (reg 15): reads PRID.
- Any other address reads 0; writes to it are ignored.
- rd_data is combinational from the current register contents.
  - No write-to-read bypass: mtc0 at edge N is visible to mfc0 after edge N.
- int_req is combinational:
  - hwirq = |(hw_int & SR.IM) & SR.IE & !SR.EXL. Uses raw hw_int, not the Cause.IP copy, so there is 0 added latency.
  - excp = (exc_code_in != 0) & !SR.EXL.
  - int_req = hwirq | excp.
- Entry, at the clock edge where int_req = 1:
  - EXL <= 1.
  - ExcCode <= hwirq ? 0 : exc_code_in. Interrupt has priority over a simultaneous exception.
  - BD <= bd_in.
  - EPC <= bd_in ? (pc_in - 4) : pc_in, with [1:0] forced to 00. Subtraction is 32-bit wrap-around.
- eret (with int_req = 0): EXL <= 0 at the edge. epc_out is valid in the same cycle as eret.
- Simultaneous events:
  - int_req and mtc0 in the same cycle: the mtc0 is discarded, because the victim instruction is flushed.
  - int_req and eret in the same cycle: entry wins; EXL stays 1 and EPC is reloaded.
  - mtc0 and eret, no int_req: mtc0 to SR applies first, then EXL is cleared. The final EXL = 0, and the other SR bits take wr_data.
- Level semantics: a device IRQ held high re-triggers immediately after eret unless the handler cleared the source or IM.
- Reset mid-handler: EXL = 0, IE = 0, so all interrupts are masked until software sets SR.

Test Plan:
- After reset: mfc0 12/13/14 -> 0; mfc0 15 -> 32'h2018_0007; with hw_int = 6'b000001, int_req stays 0.
- Timer interrupt:
  - Setup: mtc0 SR = 32'h0000_0401 (IM0 = 1, IE = 1), pc_in = 32'h0000_3010, bd_in = 0; raise hw_int[0] -> int_req = 1 in the same cycle.
  - After the edge: SR = 32'h0000_0403, Cause = 32'h0000_0400, EPC = 32'h0000_3010, int_req = 0.
- Masked interrupt: SR = 32'h0000_0801, hw_int = 6'b000001 -> int_req = 0, Cause.IP = 6'b000001 after 1 cycle; EPC unchanged.
- Exception in delay slot: SR = 0, exc_code_in = 5'd12, bd_in = 1, pc_in = 32'h0000_3020 -> int_req = 1; Cause = 32'h8000_0030, EPC = 32'h0000_301C.
- Same-cycle conflict:
  - Setup: SR = 32'h0000_0401, hw_int[0] = 1, exc_code_in = 5'd10, plus mtc0 14 = 32'h1234_5678.
  - Result: ExcCode = 0; EPC = pc_in, not 32'h1234_5678.
- eret: with EXL = 1, EPC = 32'h0000_3010, assert eret -> epc_out = 32'h0000_3010 that cycle; EXL = 0 after the edge. Held hw_int[0] re-raises int_req on the next cycle.
